rom_bus_arbiter: RTL

- Shares the CPU's external 4-bit ROM/RAM bus (data, sync, rom_cmd) between the CPU and a host port, e.g. a debug or loader port.
- The host performs 8-bit ROM read transactions at 12-bit addresses.
- The arbiter grants the host only at CPU instruction boundaries. It freezes the CPU through a clock enable, then runs a bus cycle with the same subcycle timing as the CPU.
- It sits between the CPU top level and the board pins.

---
 rtl/rom_bus_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: shares the CPU's 4-bit ROM/RAM bus with a host read port.
// The host is granted only at CPU instruction boundaries (end of subcycle 7).
// While the host owns the bus the CPU is frozen through cpu_run_en, and the
// arbiter runs one bus cycle with the CPU's own subcycle timing.
// Optional macro ROM_BUS_ARB_STARVE_GUARD_EN limits back-to-back host
// transactions to MAX_HOST_BURST before the CPU must run one instruction.
//
// state  | meaning
// RUN    | CPU owns the bus, pins follow the CPU
// H_SYNC | host cycle, sync pulse clock
// H_SUB  | host cycle, subcycles h = 0..7 (A1 A2 A3 M1 M2 idle idle idle)

module rom_bus_arbiter #(
    parameter int MAX_HOST_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cpu_cycle,
    input  logic        cpu_sync,
    input  logic        cpu_rom_cmd,
    input  logic [3:0]  cpu_data_out,
    input  logic        cpu_data_oe,
    output logic        cpu_run_en,
    input  logic [3:0]  bus_data_in,
    output logic [3:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        bus_sync,
    output logic        bus_rom_cmd,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        H_SYNC = 2'd1,
        H_SUB  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  h;
    logic [2:0]  h_nxt;
    logic [11:0] addr;
    logic        guard_ok;
    logic        accept;

    assign accept = req_valid && req_ready;

`ifdef ROM_BUS_ARB_STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_HOST_BURST + 1);
    logic [BW-1:0] burst_cnt;

    // Count consecutive host grants; a CPU instruction start clears the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else if (accept) begin
            burst_cnt <= burst_cnt + BW'(1);
        end else if (state == RUN && cpu_run_en && cpu_cycle == 3'd0) begin
            burst_cnt <= '0;
        end
    end

    assign guard_ok = (32'(burst_cnt) < 32'(MAX_HOST_BURST));
`else
    assign guard_ok = 1'b1;
`endif

    // State, subcycle counter, latched address and response capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            h         <= 3'd0;
            addr      <= 12'h000;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            h         <= h_nxt;
            rsp_valid <= (state == H_SUB) && (h == 3'd7);
            if (accept) begin
                addr <= req_addr;
            end
            if (state == H_SUB && h == 3'd3) begin
                rsp_data[7:4] <= bus_data_in;
            end
            if (state == H_SUB && h == 3'd4) begin
                rsp_data[3:0] <= bus_data_in;
            end
        end
    end

    // Next-state logic, bus pin mux and CPU clock enable.
    always_comb begin
        state_nxt    = state;
        h_nxt        = h;
        cpu_run_en   = 1'b0;
        req_ready    = 1'b0;
        bus_sync     = 1'b0;
        bus_rom_cmd  = 1'b1;
        bus_data_out = 4'h0;
        bus_data_oe  = 1'b0;
        case (state)
            RUN: begin
                bus_sync     = cpu_sync;
                bus_rom_cmd  = cpu_rom_cmd;
                bus_data_out = cpu_data_out;
                bus_data_oe  = cpu_data_oe;
                req_ready    = (cpu_cycle == 3'd7) && guard_ok;
                // Freezing at cycle 7 consumes no CPU edge, so it resumes cleanly.
                cpu_run_en   = !(req_valid && req_ready);
                if (req_valid && req_ready) begin
                    state_nxt = H_SYNC;
                end
            end
            H_SYNC: begin
                bus_sync  = 1'b1;
                state_nxt = H_SUB;
                h_nxt     = 3'd0;
            end
            H_SUB: begin
                case (h)
                    3'd0: begin
                        bus_data_out = addr[3:0];
                        bus_data_oe  = 1'b1;
                    end
                    3'd1: begin
                        bus_data_out = addr[7:4];
                        bus_data_oe  = 1'b1;
                    end
                    3'd2: begin
                        bus_data_out = addr[11:8];
                        bus_data_oe  = 1'b1;
                        bus_rom_cmd  = 1'b0;
                    end
                    default: begin
                        bus_data_out = 4'h0;
                        bus_data_oe  = 1'b0;
                    end
                endcase
                if (h == 3'd7) begin
                    req_ready = guard_ok;
                    if (req_valid && guard_ok) begin
                        state_nxt = H_SYNC;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    h_nxt = h + 3'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                h_nxt     = 3'd0;
            end
        endcase
    end

endmodule
